sprite_pixel_arbiter: RTL and testbench

- Per-pixel layer arbiter and sprite-ROM address sequencer between the VGA timing core and the screen.
- Latches all sprite positions once per frame (no mid-frame tearing), decides which layer owns each pixel, and drives the two shared sprite ROMs (ghost, pac).
- Resolves ghost transparency from the returned ROM data, then emits a registered 12-bit colour two pixel strobes after the coordinate.
- Also reports per-frame pac/ghost geometric overlap.

---
 rtl/sprite_pixel_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_sprite_pixel_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_pixel_arbiter.sv
// Per-pixel layer arbiter and sprite-ROM address sequencer.
// Sprite positions are sampled once per frame; the colour leaves two pixel strobes after its coordinate.
module sprite_pixel_arbiter #(
  parameter int unsigned SPR      = 32,
  parameter logic [11:0] WALL_RGB = 12'hFFF,
  parameter logic [11:0] BEAN_RGB = 12'hFF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        frame_start,
  input  logic        de,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        over,
  input  logic        is_wall,
  input  logic        is_bean,
  input  logic [9:0]  pac_x,
  input  logic [8:0]  pac_y,
  input  logic [1:0]  pac_dir,
  input  logic [9:0]  g1_x,
  input  logic [9:0]  g2_x,
  input  logic [9:0]  g3_x,
  input  logic [9:0]  g4_x,
  input  logic [8:0]  g1_y,
  input  logic [8:0]  g2_y,
  input  logic [8:0]  g3_y,
  input  logic [8:0]  g4_y,
  output logic [9:0]  ghost_addr,
  input  logic [11:0] ghost_rgb,
  output logic [9:0]  pac_addr,
  input  logic [11:0] pac_rgb,
  output logic [11:0] pix_rgb,
  output logic        pix_valid,
  output logic        collide
);

  localparam int unsigned SW  = $clog2(SPR);
  localparam int unsigned AW  = 10;
  localparam int unsigned XW  = 10;
  localparam int unsigned YW  = 9;
  localparam int unsigned XEW = XW + 1;
  localparam int unsigned YEW = YW + 1;
  localparam int unsigned NG  = 4;
  localparam int unsigned GSW = 3;
  localparam int unsigned CW  = 12;

  // Inclusive-exclusive box test; end coordinates one bit wider so they never wrap.
  function automatic logic hit_f(input logic [YW-1:0] row, input logic [XW-1:0] col,
                                 input logic [XW-1:0] x, input logic [YW-1:0] y);
    logic [YEW-1:0] y_end;
    logic [XEW-1:0] x_end;
    y_end = {1'b0, y} + YEW'(SPR);
    x_end = {1'b0, x} + XEW'(SPR);
    return (row >= y) && ({1'b0, row} < y_end) && (col >= x) && ({1'b0, col} < x_end);
  endfunction

  // SPR is a power of two, so hi*SPR+lo is a plain concatenation.
  function automatic logic [AW-1:0] rom_addr(input logic [SW-1:0] hi, input logic [SW-1:0] lo);
    return AW'({hi, lo});
  endfunction

  logic            fs;
  logic [XW-1:0]   gx_in [NG];
  logic [YW-1:0]   gy_in [NG];
  logic [XW-1:0]   gx_q  [NG];
  logic [YW-1:0]   gy_q  [NG];
  logic [XW-1:0]   gx_e  [NG];
  logic [YW-1:0]   gy_e  [NG];
  logic [XW-1:0]   px_q, px_e;
  logic [YW-1:0]   py_q, py_e;
  logic [1:0]      pdir_q, pdir_e;

  logic            over_q, wall_q, bean_q, de_q;
  logic [GSW-1:0]  gsel_q, gsel_d;
  logic [AW-1:0]   ghost_addr_q, ghost_addr_d;
  logic            pac_hit_q, pac_hit_d;
  logic [AW-1:0]   pac_addr_q, pac_addr_d;
  logic [SW-1:0]   pdx, pdy;

  logic [CW-1:0]   pix_rgb_q, pix_rgb_d;
  logic            pix_valid_q;
  logic            collide_q, collide_acc_q, coll_s1;

  assign fs = pix_en & frame_start;

  // Gather ghost coordinate ports into arrays.
  always_comb begin
    gx_in[0] = g1_x;  gy_in[0] = g1_y;
    gx_in[1] = g2_x;  gy_in[1] = g2_y;
    gx_in[2] = g3_x;  gy_in[2] = g3_y;
    gx_in[3] = g4_x;  gy_in[3] = g4_y;
  end

  // Shadow positions: sampled once per frame, parked off-screen by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NG); i++) begin
        gx_q[i] <= '1;
        gy_q[i] <= '1;
      end
      px_q   <= '1;
      py_q   <= '1;
      pdir_q <= '0;
    end else if (fs) begin
      for (int i = 0; i < int'(NG); i++) begin
        gx_q[i] <= gx_in[i];
        gy_q[i] <= gy_in[i];
      end
      px_q   <= pac_x;
      py_q   <= pac_y;
      pdir_q <= pac_dir;
    end
  end

  // The frame_start pixel belongs to the new frame, so it sees the incoming positions.
  always_comb begin
    for (int i = 0; i < int'(NG); i++) begin
      gx_e[i] = fs ? gx_in[i] : gx_q[i];
      gy_e[i] = fs ? gy_in[i] : gy_q[i];
    end
    px_e   = fs ? pac_x   : px_q;
    py_e   = fs ? pac_y   : py_q;
    pdir_e = fs ? pac_dir : pdir_q;
  end

  // Ghost select (lowest index wins) and ghost ROM address; address holds on a miss.
  always_comb begin
    gsel_d       = '0;
    ghost_addr_d = ghost_addr_q;
    for (int i = int'(NG) - 1; i >= 0; i--) begin
      if (hit_f(row_addr, col_addr, gx_e[i], gy_e[i])) begin
        gsel_d       = GSW'(i + 1);
        ghost_addr_d = rom_addr(SW'(row_addr - gy_e[i]), SW'(col_addr - gx_e[i]));
      end
    end
  end

  // Pac hit and direction-dependent ROM address (transpose / mirror of the stored sprite).
  always_comb begin
    pac_hit_d  = hit_f(row_addr, col_addr, px_e, py_e);
    pdx        = SW'(col_addr - px_e);
    pdy        = SW'(row_addr - py_e);
    pac_addr_d = pac_addr_q;
    if (pac_hit_d) begin
      case (pdir_e)
        2'b00: pac_addr_d = rom_addr(pdx, pdy);
        2'b01: pac_addr_d = rom_addr(pdx, ~pdy);
        2'b10: pac_addr_d = rom_addr(pdy, pdx);
        2'b11: pac_addr_d = rom_addr(pdy, ~pdx);
      endcase
    end
  end

  // Stage 1: pixel attributes and ROM addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      over_q       <= 1'b0;
      wall_q       <= 1'b0;
      bean_q       <= 1'b0;
      de_q         <= 1'b0;
      gsel_q       <= '0;
      ghost_addr_q <= '0;
      pac_hit_q    <= 1'b0;
      pac_addr_q   <= '0;
    end else if (pix_en) begin
      over_q       <= over;
      wall_q       <= is_wall;
      bean_q       <= is_bean;
      de_q         <= de;
      gsel_q       <= gsel_d;
      ghost_addr_q <= ghost_addr_d;
      pac_hit_q    <= pac_hit_d;
      pac_addr_q   <= pac_addr_d;
    end
  end

  // Layer priority; ghost colour 0 is transparent.
  always_comb begin
    pix_rgb_d = '0;
    if (!de_q || over_q)                      pix_rgb_d = '0;
    else if (wall_q)                          pix_rgb_d = WALL_RGB;
    else if (gsel_q != '0 && ghost_rgb != '0) pix_rgb_d = ghost_rgb;
    else if (bean_q)                          pix_rgb_d = BEAN_RGB;
    else if (pac_hit_q)                       pix_rgb_d = pac_rgb;
  end

  // Stage 2: output colour and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_rgb_q   <= '0;
      pix_valid_q <= 1'b0;
    end else if (pix_en) begin
      pix_rgb_q   <= pix_rgb_d;
      pix_valid_q <= de_q;
    end
  end

  assign coll_s1 = pac_hit_q & (gsel_q != '0) & ~over_q;

  // Per-frame overlap accumulator; the closing frame's result is published at frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      collide_acc_q <= 1'b0;
      collide_q     <= 1'b0;
    end else if (pix_en) begin
      if (frame_start) begin
        collide_q     <= collide_acc_q | coll_s1;
        collide_acc_q <= 1'b0;
      end else begin
        collide_acc_q <= collide_acc_q | coll_s1;
      end
    end
  end

  assign ghost_addr = ghost_addr_q;
  assign pac_addr   = pac_addr_q;
  assign pix_rgb    = pix_rgb_q;
  assign pix_valid  = pix_valid_q;
  assign collide    = collide_q;

endmodule

// File: tb/tb_sprite_pixel_arbiter.sv
// Bench for sprite_pixel_arbiter: table of pixels plus hand sequences, colour checked via a queue.
module tb_sprite_pixel_arbiter;

  localparam int FX = 700;
  localparam int FY = 400;

  logic        clk = 1'b0;
  logic        rst, pix_en, frame_start, de, over, is_wall, is_bean;
  logic [8:0]  row_addr, pac_y, g1_y, g2_y, g3_y, g4_y;
  logic [9:0]  col_addr, pac_x, g1_x, g2_x, g3_x, g4_x;
  logic [1:0]  pac_dir;
  logic [9:0]  ghost_addr, pac_addr;
  logic [11:0] ghost_rgb, pac_rgb, pix_rgb;
  logic        pix_valid, collide;

  int gmode = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // ROM models: data is a tagged copy of the address so each source is recognisable.
  assign ghost_rgb = (gmode == 0) ? (12'h800 | 12'(ghost_addr)) :
                     ((gmode == 1) ? 12'h000 : 12'h0F0);
  assign pac_rgb   = 12'h400 | 12'(pac_addr);

  sprite_pixel_arbiter dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .frame_start(frame_start), .de(de),
    .row_addr(row_addr), .col_addr(col_addr), .over(over), .is_wall(is_wall), .is_bean(is_bean),
    .pac_x(pac_x), .pac_y(pac_y), .pac_dir(pac_dir),
    .g1_x(g1_x), .g2_x(g2_x), .g3_x(g3_x), .g4_x(g4_x),
    .g1_y(g1_y), .g2_y(g2_y), .g3_y(g3_y), .g4_y(g4_y),
    .ghost_addr(ghost_addr), .ghost_rgb(ghost_rgb), .pac_addr(pac_addr), .pac_rgb(pac_rgb),
    .pix_rgb(pix_rgb), .pix_valid(pix_valid), .collide(collide)
  );

  always #5 clk = ~clk;

  typedef struct {
    int su; int row; int col;
    bit de; bit ov; bit wl; bit bn;
    int gm; int ega; int epa; int erg; bit ev;
    string nm;
  } vec_t;

  typedef struct { int px, py, pd, g1x, g1y, g2x, g2y, g3x, g3y, g4x, g4y; } su_t;

  typedef struct { logic [11:0] rgb; logic vld; bit chk; string nm; } sb_t;

  vec_t tbl [19];
  su_t  sus [10];
  sb_t  exp_q [$];

  function automatic vec_t pv(input int su, input int row, input int col,
                              input bit de_v, input bit ov, input bit wl, input bit bn,
                              input int gm, input int ega, input int epa, input int erg,
                              input bit ev, input string nm);
    vec_t v;
    v.su = su; v.row = row; v.col = col; v.de = de_v; v.ov = ov; v.wl = wl; v.bn = bn;
    v.gm = gm; v.ega = ega; v.epa = epa; v.erg = erg; v.ev = ev; v.nm = nm;
    return v;
  endfunction

  function automatic su_t mks(input int px, input int py, input int pd,
                              input int a, input int b, input int c, input int d,
                              input int e, input int f, input int g, input int h);
    su_t s;
    s.px = px; s.py = py; s.pd = pd;
    s.g1x = a; s.g1y = b; s.g2x = c; s.g2y = d; s.g3x = e; s.g3y = f; s.g4x = g; s.g4y = h;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // One pixel strobe; the colour of the previous strobe is popped from the queue and checked.
  task automatic step(input vec_t v, input bit fs, input bit chk_it);
    sb_t e;
    row_addr = 9'(v.row); col_addr = 10'(v.col);
    de = v.de; over = v.ov; is_wall = v.wl; is_bean = v.bn;
    frame_start = fs; pix_en = 1'b1;
    e.rgb = 12'(v.erg); e.vld = v.ev; e.chk = chk_it; e.nm = v.nm;
    exp_q.push_back(e);
    @(posedge clk); #1;
    pix_en = 1'b0; frame_start = 1'b0;
    gmode = v.gm;
    if (chk_it) begin
      chk({v.nm, "_gaddr"}, 32'(ghost_addr), 32'(v.ega));
      chk({v.nm, "_paddr"}, 32'(pac_addr), 32'(v.epa));
    end
    if (exp_q.size() > 1) begin
      e = exp_q.pop_front();
      if (e.chk) begin
        chk({e.nm, "_rgb"}, 32'(pix_rgb), 32'(e.rgb));
        chk({e.nm, "_valid"}, 32'(pix_valid), 32'(e.vld));
      end
    end
  endtask

  task automatic idle();
    step(pv(0, 500, 1000, 0, 0, 0, 0, gmode, 0, 0, 0, 0, "idle"), 1'b0, 1'b0);
  endtask

  task automatic frame(input int s);
    pac_x = 10'(sus[s].px); pac_y = 9'(sus[s].py); pac_dir = 2'(sus[s].pd);
    g1_x = 10'(sus[s].g1x); g1_y = 9'(sus[s].g1y);
    g2_x = 10'(sus[s].g2x); g2_y = 9'(sus[s].g2y);
    g3_x = 10'(sus[s].g3x); g3_y = 9'(sus[s].g3y);
    g4_x = 10'(sus[s].g4x); g4_y = 9'(sus[s].g4y);
    step(pv(s, 0, 0, 0, 0, 0, 0, gmode, 0, 0, 0, 0, "frame"), 1'b1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: actual running required finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cur;
    sus[0] = mks(300, 200, 0, 100, 50,  FX, FY,  FX, FY,  FX, FY);
    sus[1] = mks(300, 200, 0, 400, 300, 100, 50, FX, FY,  410, 300);
    sus[2] = mks(0, 0, 0, FX, FY, FX, FY, FX, FY, FX, FY);
    sus[3] = mks(0, 0, 1, FX, FY, FX, FY, FX, FY, FX, FY);
    sus[4] = mks(0, 0, 2, FX, FY, FX, FY, FX, FY, FX, FY);
    sus[5] = mks(0, 0, 3, FX, FY, FX, FY, FX, FY, FX, FY);
    sus[6] = mks(FX, FY, 0, 100, 50, FX, FY, FX, FY, FX, FY);
    sus[7] = mks(FX, FY, 0, 400, 50, FX, FY, FX, FY, FX, FY);
    sus[8] = mks(200, 200, 0, FX, FY, FX, FY, 200, 200, FX, FY);
    sus[9] = mks(300, 200, 0, FX, FY, FX, FY, FX, FY, FX, FY);

    //            su  row  col de ov wl bn gm  ega  epa  rgb     v
    tbl[0]  = pv(0,  60, 110, 1, 0, 0, 0, 0, 330,   0, 'h94A, 1, "g1_hit");
    tbl[1]  = pv(0, 210, 305, 1, 0, 0, 0, 0, 330, 170, 'h4AA, 1, "pac_d0");
    tbl[2]  = pv(0, 300,  10, 1, 0, 0, 1, 0, 330, 170, 'hFF0, 1, "bean");
    tbl[3]  = pv(0, 300,  10, 1, 0, 0, 0, 0, 330, 170, 'h000, 1, "blank");
    tbl[4]  = pv(0, 210, 306, 0, 0, 0, 0, 0, 330, 202, 'h000, 0, "de_low");
    tbl[5]  = pv(0,  60, 110, 1, 1, 0, 0, 0, 330, 202, 'h000, 1, "over");
    tbl[6]  = pv(0,  51, 101, 1, 0, 1, 0, 0,  33, 202, 'hFFF, 1, "wall");
    tbl[7]  = pv(1,  55, 105, 1, 0, 0, 1, 1, 165, 202, 'hFF0, 1, "g2_transp");
    tbl[8]  = pv(1,  55, 105, 1, 0, 0, 1, 2, 165, 202, 'h0F0, 1, "g2_opaque");
    tbl[9]  = pv(1,  55, 105, 1, 0, 1, 1, 2, 165, 202, 'hFFF, 1, "wall_over_ghost");
    tbl[10] = pv(1, 305, 415, 1, 0, 0, 0, 0, 175, 202, 'h8AF, 1, "g1_beats_g4");
    tbl[11] = pv(1, 305, 435, 1, 0, 0, 0, 0, 185, 202, 'h8B9, 1, "g4_only");
    tbl[12] = pv(1, 305, 435, 1, 0, 0, 0, 1, 185, 202, 'h000, 1, "g4_transp");
    tbl[13] = pv(2,   3,   5, 1, 0, 0, 0, 0, 185, 163, 'h4A3, 1, "pac_dir00");
    tbl[14] = pv(3,   3,   5, 1, 0, 0, 0, 0, 185, 188, 'h4BC, 1, "pac_dir01");
    tbl[15] = pv(4,   3,   5, 1, 0, 0, 0, 0, 185, 101, 'h465, 1, "pac_dir10");
    tbl[16] = pv(5,   3,   5, 1, 0, 0, 0, 0, 185, 122, 'h47A, 1, "pac_dir11");
    tbl[17] = pv(5,   3,  32, 1, 0, 0, 0, 0, 185, 122, 'h000, 1, "pac_col_edge");
    tbl[18] = pv(5,  31,  31, 1, 0, 0, 0, 0, 185, 992, 'h7E0, 1, "pac_corner");

    rst = 1'b1; pix_en = 1'b0; frame_start = 1'b0; de = 1'b0; over = 1'b0;
    is_wall = 1'b0; is_bean = 1'b0; row_addr = '0; col_addr = '0;
    pac_x = '0; pac_y = '0; pac_dir = '0;
    g1_x = '0; g2_x = '0; g3_x = '0; g4_x = '0; g1_y = '0; g2_y = '0; g3_y = '0; g4_y = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_rgb", 32'(pix_rgb), 32'h0);
    chk("rst_valid", 32'(pix_valid), 32'h0);
    chk("rst_collide", 32'(collide), 32'h0);
    chk("rst_gaddr", 32'(ghost_addr), 32'h0);
    chk("rst_paddr", 32'(pac_addr), 32'h0);

    // Before any frame_start the shadows are off-screen: nothing hits.
    g1_x = 10'd100; g1_y = 9'd50;
    step(pv(0, 60, 110, 1, 0, 0, 0, 0, 0, 0, 'h000, 1, "preframe"), 1'b0, 1'b1);
    idle();

    cur = -1;
    for (int i = 0; i < 19; i++) begin
      if (tbl[i].su != cur) begin
        frame(tbl[i].su);
        cur = tbl[i].su;
      end
      step(tbl[i], 1'b0, 1'b1);
    end

    // Mid-frame position change is ignored until the next frame_start.
    frame(6);
    step(pv(6, 60, 100, 1, 0, 0, 0, 0, 320, 992, 'h940, 1, "tear_a"), 1'b0, 1'b1);
    g1_x = 10'd400;
    step(pv(6, 60, 131, 1, 0, 0, 0, 0, 351, 992, 'h95F, 1, "tear_b"), 1'b0, 1'b1);
    step(pv(6, 60, 400, 1, 0, 0, 0, 0, 351, 992, 'h000, 1, "tear_c"), 1'b0, 1'b1);
    frame(7);
    step(pv(7, 60, 100, 1, 0, 0, 0, 0, 351, 992, 'h000, 1, "tear_d"), 1'b0, 1'b1);
    step(pv(7, 60, 420, 1, 0, 0, 0, 0, 340, 992, 'h954, 1, "tear_e"), 1'b0, 1'b1);
    step(pv(7, 60, 432, 1, 0, 0, 0, 0, 340, 992, 'h000, 1, "tear_xedge"), 1'b0, 1'b1);
    step(pv(7, 82, 420, 1, 0, 0, 0, 0, 340, 992, 'h000, 1, "tear_yedge"), 1'b0, 1'b1);
    step(pv(7, 81, 420, 1, 0, 0, 0, 0, 1012, 992, 'hBF4, 1, "tear_ylast"), 1'b0, 1'b1);
    frame(3);
    pac_dir = 2'b10;
    step(pv(3, 3, 5, 1, 0, 0, 0, 0, 1012, 188, 'h4BC, 1, "dir_shadow"), 1'b0, 1'b1);

    // Collision: reported for the frame after the overlap, then cleared.
    frame(8);
    chk("col_prev", 32'(collide), 32'h0);
    step(pv(8, 210, 210, 1, 0, 0, 0, 0, 330, 330, 'h94A, 1, "col_pix"), 1'b0, 1'b1);
    chk("col_same_frame", 32'(collide), 32'h0);
    idle();
    chk("col_during", 32'(collide), 32'h0);
    frame(9);
    chk("col_set", 32'(collide), 32'h1);
    idle();
    chk("col_hold", 32'(collide), 32'h1);
    frame(9);
    chk("col_clear", 32'(collide), 32'h0);
    frame(8);
    step(pv(8, 210, 210, 1, 0, 0, 0, 0, 330, 330, 'h94A, 1, "col_pix2"), 1'b0, 1'b1);
    frame(9);
    chk("col_same_edge", 32'(collide), 32'h1);
    frame(9);
    chk("col_clear2", 32'(collide), 32'h0);
    frame(8);
    step(pv(8, 210, 210, 1, 1, 0, 0, 0, 330, 330, 'h000, 1, "col_over_pix"), 1'b0, 1'b1);
    idle();
    frame(9);
    chk("col_over", 32'(collide), 32'h0);

    // pix_en low: everything holds, including a frame_start that is not strobed.
    frame(0);
    step(pv(0, 60, 110, 1, 0, 0, 0, 0, 330, 330, 'h94A, 1, "hold_src"), 1'b0, 1'b1);
    idle();
    g1_x = 10'd400;
    for (int k = 0; k < 5; k++) begin
      frame_start = 1'b1; de = 1'b1; is_wall = 1'b1;
      row_addr = 9'(210 + k); col_addr = 10'(305 + k);
      @(posedge clk); #1;
      chk($sformatf("hold%0d_rgb", k), 32'(pix_rgb), 32'h94A);
      chk($sformatf("hold%0d_valid", k), 32'(pix_valid), 32'h1);
      chk($sformatf("hold%0d_gaddr", k), 32'(ghost_addr), 32'd330);
      chk($sformatf("hold%0d_paddr", k), 32'(pac_addr), 32'd330);
    end
    frame_start = 1'b0;
    step(pv(0, 60, 110, 1, 0, 0, 0, 0, 330, 330, 'h94A, 1, "hold_fs_ignored"), 1'b0, 1'b1);

    // Reset mid-frame empties the pipeline and parks the shadows.
    rst = 1'b1; pix_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; pix_en = 1'b0;
    exp_q.delete();
    chk("mrst_rgb", 32'(pix_rgb), 32'h0);
    chk("mrst_valid", 32'(pix_valid), 32'h0);
    chk("mrst_gaddr", 32'(ghost_addr), 32'h0);
    chk("mrst_paddr", 32'(pac_addr), 32'h0);
    step(pv(0, 60, 110, 1, 0, 0, 0, 0, 0, 0, 'h000, 1, "mrst_offscreen"), 1'b0, 1'b1);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
